// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: opcodes, NOP encoding, datapath width, FSM states.
package instruction_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 6;
  localparam int CNT_W   = 32;

  localparam logic [OPC_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OPC_W-1:0] OP_J    = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OPC_W-1:0] OP_HALT = 6'h3F;

  // Canonical bubble: NOP opcode with all other fields zero.
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 26'h0};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [OPC_W-1:0] opc);
    return opc == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Fetch/bubble event counters; both wrap and clear on reset.
module fetch_perf_counter
  import instruction_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_inc,
  input  logic             bubble_inc,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] bubble_count
);

  // Independent free-running counters, modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fetch_inc)  fetch_count  <= fetch_count + CNT_W'(1);
      if (bubble_inc) bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Genie IF stage: PC, instruction-memory address, IF/ID register, HALT parking.
// Optional FETCH_PERF_COUNTERS_EN adds FetchCount/BubbleCount outputs.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int               WIDTH    = INSTR_W,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IsStall_IF,
  input  logic             IsStall_ID,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] RedirectPC,
  output logic [WIDTH-1:0] IMemAddr,
  input  logic [WIDTH-1:0] IMemData,
  input  logic             IMemReady,
  output logic [WIDTH-1:0] IR_ID,
  output logic [WIDTH-1:0] PC_ID,
  output logic             Halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] FetchCount,
  output logic [CNT_W-1:0] BubbleCount
`endif
);

  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_INSTR);

  fetch_state_e     state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt, pc_inc;
  logic [WIDTH-1:0] ir_id, ir_nxt;
  logic [WIDTH-1:0] pc_id, pcid_nxt;
  logic             fetch_evt, bubble_evt;

  // Natural wrap at 2^WIDTH.
  assign pc_inc = pc + WIDTH'(4);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next PC / IF/ID / state, priority redirect > stall > halted > not-ready > fetch.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir_id;
    pcid_nxt   = pc_id;
    fetch_evt  = 1'b0;
    bubble_evt = 1'b0;
    if (Redirect) begin
      // Also cancels a HALT fetched down the wrong path.
      pc_nxt     = {RedirectPC[WIDTH-1:2], 2'b00};
      ir_nxt     = NOP_W;
      pcid_nxt   = '0;
      state_nxt  = ST_RUN;
      bubble_evt = 1'b1;
    end else if (IsStall_IF || IsStall_ID) begin
      // ID stall keeps IF/ID; IF-only stall bubbles so decode does not see the word twice.
      if (!IsStall_ID) begin
        ir_nxt     = NOP_W;
        pcid_nxt   = '0;
        bubble_evt = 1'b1;
      end
    end else if (state == ST_HALTED || !IMemReady) begin
      ir_nxt     = NOP_W;
      pcid_nxt   = '0;
      bubble_evt = 1'b1;
    end else begin
      ir_nxt    = IMemData;
      pcid_nxt  = pc_inc;
      fetch_evt = 1'b1;
      // HALT parks the PC on its own address.
      if (is_halt(IMemData[WIDTH-1 -: OPC_W])) state_nxt = ST_HALTED;
      else                                     pc_nxt    = pc_inc;
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      ir_id <= NOP_W;
      pc_id <= '0;
    end else begin
      pc    <= pc_nxt;
      ir_id <= ir_nxt;
      pc_id <= pcid_nxt;
    end
  end

  assign IMemAddr = pc;
  assign IR_ID    = ir_id;
  assign PC_ID    = pc_id;
  assign Halted   = (state == ST_HALTED);

  // Redirect targets are word aligned; low bits are dropped.
  logic unused_rpc;
  assign unused_rpc = ^RedirectPC[1:0];

`ifdef FETCH_PERF_COUNTERS_EN
  fetch_perf_counter u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_inc    (fetch_evt),
    .bubble_inc   (bubble_evt),
    .fetch_count  (FetchCount),
    .bubble_count (BubbleCount)
  );
`else
  logic unused_evt;
  assign unused_evt = fetch_evt ^ bubble_evt;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a combinational instruction memory model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP_W  = 32'h0000_0000;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk, rst_n;
  logic        IsStall_IF, IsStall_ID, Redirect, IMemReady;
  logic [31:0] RedirectPC, IMemAddr, IMemData, IR_ID, PC_ID;
  logic        Halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] FetchCount, BubbleCount;
`endif

  logic [31:0] halt_addr;
  int          n_pass, n_tot;

  instruction_fetch #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IsStall_IF (IsStall_IF),
    .IsStall_ID (IsStall_ID),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IMemAddr   (IMemAddr),
    .IMemData   (IMemData),
    .IMemReady  (IMemReady),
    .IR_ID      (IR_ID),
    .PC_ID      (PC_ID),
    .Halted     (Halted)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .FetchCount  (FetchCount),
    .BubbleCount (BubbleCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-HALT words carry opcode 6'h04 and the low address bits.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {6'h04, a[25:0]};
  endfunction

  always_comb IMemData = (IMemAddr == halt_addr) ? HALT_W : word(IMemAddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                        input logic [31:0] pcid, input logic h);
    chk({tag, ".pc"},   IMemAddr, pc);
    chk({tag, ".ir"},   IR_ID, ir);
    chk({tag, ".pcid"}, PC_ID, pcid);
    chk({tag, ".halt"}, {31'b0, Halted}, {31'b0, h});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0; n_tot = 0;
    rst_n = 1'b0; IsStall_IF = 0; IsStall_ID = 0; Redirect = 0;
    RedirectPC = '0; IMemReady = 0; halt_addr = 32'hFFFF_FFFF;
    #12;
    chk_if("rst", 32'h0, NOP_W, 32'h0, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("rst.fcnt", FetchCount, 32'd0);
    chk("rst.bcnt", BubbleCount, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1; IMemReady = 1'b1;

    // Sequential fetch.
    step(); chk_if("seq0", 32'h4, word(32'h0), 32'h4, 1'b0);
    step(); chk_if("seq1", 32'h8, word(32'h4), 32'h8, 1'b0);

    // Both stalls hold everything.
    IsStall_IF = 1; IsStall_ID = 1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_if("stall", 32'h8, word(32'h4), 32'h8, 1'b0);
    end
    IsStall_IF = 0; IsStall_ID = 0;
    step(); chk_if("resume", 32'hC, word(32'h8), 32'hC, 1'b0);

    // IF-only stall: bubble, PC held.
    IsStall_IF = 1;
    step(); chk_if("ifstall", 32'hC, NOP_W, 32'h0, 1'b0);
    IsStall_IF = 0;
    halt_addr = 32'h10;
    step(); chk_if("pre_halt", 32'h10, word(32'hC), 32'h10, 1'b0);

    // HALT at 0x10 parks.
    step(); chk_if("halt", 32'h10, HALT_W, 32'h14, 1'b1);
    step(); chk_if("halted", 32'h10, NOP_W, 32'h0, 1'b1);
    halt_addr = 32'hFFFF_FFFF;

    // Redirect out of HALTED.
    Redirect = 1; RedirectPC = 32'h20;
    step(); chk_if("redir20", 32'h20, NOP_W, 32'h0, 1'b0);
    Redirect = 0;
    step(); chk_if("tgt20", 32'h24, word(32'h20), 32'h24, 1'b0);

    // Redirect beats both stalls; low bits forced to zero.
    Redirect = 1; RedirectPC = 32'h43; IsStall_IF = 1; IsStall_ID = 1;
    step(); chk_if("redir40", 32'h40, NOP_W, 32'h0, 1'b0);
    Redirect = 0; IsStall_IF = 0; IsStall_ID = 0;
    step(); chk_if("tgt40", 32'h44, word(32'h40), 32'h44, 1'b0);

    // Memory not ready: two bubbles.
    IMemReady = 0;
    step(); chk_if("nrdy0", 32'h44, NOP_W, 32'h0, 1'b0);
    step(); chk_if("nrdy1", 32'h44, NOP_W, 32'h0, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    // bubbles: IF stall 1, halted 1, redirects 2, not-ready 2
    chk("bcnt", BubbleCount, 32'd6);
    chk("fcnt", FetchCount, 32'd7);
`endif
    IMemReady = 1;
    step(); chk_if("rdy", 32'h48, word(32'h44), 32'h48, 1'b0);

    // PC wrap at top of address space.
    Redirect = 1; RedirectPC = 32'hFFFF_FFFC;
    step(); chk_if("redirtop", 32'hFFFF_FFFC, NOP_W, 32'h0, 1'b0);
    Redirect = 0;
    step(); chk_if("wrap", 32'h0, word(32'hFFFF_FFFC), 32'h0, 1'b0);

    // Async reset in the middle of a stall at 0xFFFFFFFC.
    Redirect = 1; RedirectPC = 32'hFFFF_FFFC;
    step();
    Redirect = 0; IsStall_IF = 1; IsStall_ID = 1;
    step(); chk_if("stalltop", 32'hFFFF_FFFC, NOP_W, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_if("async_rst", 32'h0, NOP_W, 32'h0, 1'b0);
    IsStall_IF = 0; IsStall_ID = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(); chk_if("post_rst", 32'h4, word(32'h0), 32'h4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
